// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and state encodings, instruction field positions,
// flag bit indices and opcode class helpers.
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_MUL = 5'd3,
        OP_MOV = 5'd4,
        OP_AND = 5'd9,
        OP_OR  = 5'd10,
        OP_XOR = 5'd11,
        OP_NOT = 5'd12,
        OP_LDR = 5'd17,
        OP_STR = 5'd19,
        OP_JE  = 5'd25,
        OP_JNE = 5'd26,
        OP_JGT = 5'd27,
        OP_JGE = 5'd28,
        OP_JLT = 5'd29,
        OP_JLE = 5'd30
    } opcode_e;

    typedef enum logic [2:0] {
        CU_RST    = 3'd0,
        CU_FETCH  = 3'd1,
        CU_DECODE = 3'd2,
        CU_EXEC   = 3'd3,
        CU_MEM    = 3'd4,
        CU_WB     = 3'd5,
        CU_BRANCH = 3'd6,
        CU_TRAP   = 3'd7
    } cu_state_e;

    localparam int OPC_HI     = 31;
    localparam int OPC_LO     = 27;
    localparam int RD_HI      = 26;
    localparam int RD_LO      = 23;
    localparam int RS1_HI     = 22;
    localparam int RS1_LO     = 19;
    localparam int RS2_HI     = 18;
    localparam int RS2_LO     = 15;
    localparam int IMM_EN_BIT = 14;
    localparam int IMM_HI     = 13;
    localparam int IMM_LO     = 0;

    localparam int Z_BIT = 3;
    localparam int N_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    function automatic logic is_alu_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_MOV,
            OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        case (op)
            OP_JE, OP_JNE, OP_JGT, OP_JGE, OP_JLT, OP_JLE: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// Control-unit bus: instruction/memory handshake inputs and datapath control outputs.
interface control_unit_mc_if #(parameter int N = 32);

    logic [N-1:0] instr;
    logic         mem_ready;
    logic [3:0]   alu_flags;
    logic [4:0]   alu_ctrl;
    logic         src_b_imm;
    logic         ir_we;
    logic         pc_we;
    logic         pc_src;
    logic         reg_we;
    logic         mem_req;
    logic         mem_we;
    logic [3:0]   flags_q;
    logic         trap;

    modport master (
        input  instr, mem_ready, alu_flags,
        output alu_ctrl, src_b_imm, ir_we, pc_we, pc_src, reg_we,
               mem_req, mem_we, flags_q, trap
    );

    modport slave (
        output instr, mem_ready, alu_flags,
        input  alu_ctrl, src_b_imm, ir_we, pc_we, pc_src, reg_we,
               mem_req, mem_we, flags_q, trap
    );

endinterface

// File: rtl/branch_cond.sv
// Conditional-jump evaluator over the registered Z/N/C/V flags; not-taken for non-jumps.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z, n, v;
    logic unused_c;

    assign z        = flags[Z_BIT];
    assign n        = flags[N_BIT];
    assign v        = flags[V_BIT];
    assign unused_c = flags[C_BIT];

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JE:   taken = z;
            OP_JNE:  taken = !z;
            OP_JGT:  taken = !z && (n == v);
            OP_JGE:  taken = (n == v);
            OP_JLT:  taken = (n != v);
            OP_JLE:  taken = z || (n != v);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: fetch/decode/execute sequencer driving ALU, register-file,
// memory and PC strobes, plus the SUB-loaded flag register and sticky trap.
module control_unit_mc
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input logic               clk,
    input logic               rst_n,
    control_unit_mc_if.master bus
);

    localparam logic [2:0] S_RST    = CU_RST;
    localparam logic [2:0] S_FETCH  = CU_FETCH;
    localparam logic [2:0] S_DECODE = CU_DECODE;
    localparam logic [2:0] S_EXEC   = CU_EXEC;
    localparam logic [2:0] S_MEM    = CU_MEM;
    localparam logic [2:0] S_WB     = CU_WB;
    localparam logic [2:0] S_BRANCH = CU_BRANCH;
    localparam logic [2:0] S_TRAP   = CU_TRAP;

    logic [2:0]   state, state_nxt;
    logic [4:0]   op_q;
    logic         imm_en_q;
    logic [3:0]   flags_r;
    logic         trap_r;
    logic         taken;
    logic         fetch_done;
    logic [N-1:0] unused_instr;

    assign unused_instr = bus.instr;
    assign fetch_done   = (state == S_FETCH) && bus.mem_ready;

    branch_cond u_branch_cond (
        .opcode (op_q),
        .flags  (flags_r),
        .taken  (taken)
    );

    // Opcode and imm_en are captured with the IR write so DECODE can classify them.
    always_ff @(posedge clk) begin
        if (fetch_done) begin
            op_q     <= bus.instr[OPC_HI:OPC_LO];
            imm_en_q <= bus.instr[IMM_EN_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RST;
            flags_r <= 4'd0;
            trap_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_EXEC) && (op_q == OP_SUB))
                flags_r <= bus.alu_flags;
            if (state_nxt == S_TRAP)
                trap_r <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_alu_op(op_q) || is_mem_op(op_q)) state_nxt = S_EXEC;
                else if (is_jump(op_q))                 state_nxt = S_BRANCH;
                else                                    state_nxt = S_TRAP;
            end
            S_EXEC:   state_nxt = is_mem_op(op_q) ? S_MEM : S_WB;
            S_MEM:    if (bus.mem_ready) state_nxt = (op_q == OP_LDR) ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_RST;
        endcase
    end

    // Address operand stays selected through MEM so the effective address is stable.
    always_comb begin
        bus.alu_ctrl  = 5'd0;
        bus.src_b_imm = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 1'b0;
        bus.reg_we    = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ready;
                bus.pc_we   = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alu_ctrl  = op_q;
                bus.src_b_imm = imm_en_q | is_mem_op(op_q);
            end
            S_MEM: begin
                bus.alu_ctrl  = op_q;
                bus.src_b_imm = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = (op_q == OP_STR);
            end
            S_WB:     bus.reg_we = 1'b1;
            S_BRANCH: begin
                bus.alu_ctrl = op_q;
                bus.pc_src   = 1'b1;
                bus.pc_we    = taken;
            end
            default: ;
        endcase
    end

    assign bus.flags_q = flags_r;
    assign bus.trap    = trap_r;

endmodule

// File: tb/tb_control_unit_mc.sv
// Randomized bench for control_unit_mc against an instruction-level reference model.
module tb_control_unit_mc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_unit_mc_if #(.N(32)) bus ();

    control_unit_mc #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [16:0] FULL   = 17'h1FFFF;
    localparam logic [16:0] NO_SBI = 17'h1F7FF;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  m_flags  = 4'd0;
    logic        m_trap   = 1'b0;
    logic [3:0]  last_af;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] observed();
        return {bus.alu_ctrl, bus.src_b_imm, bus.ir_we, bus.pc_we, bus.pc_src,
                bus.reg_we, bus.mem_req, bus.mem_we, bus.flags_q, bus.trap};
    endfunction

    function automatic logic [16:0] expv(input logic [4:0] alu, input logic sbi,
                                         input logic ir, input logic pcwe, input logic pcsrc,
                                         input logic regwe, input logic mreq, input logic mwe);
        return {alu, sbi, ir, pcwe, pcsrc, regwe, mreq, mwe, m_flags, m_trap};
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12,
                          5'd17, 5'd19, [5'd25:5'd30]};
    endfunction

    function automatic logic jump_taken(input logic [4:0] op, input logic [3:0] f);
        logic z, n, v;
        z = f[3]; n = f[2]; v = f[0];
        case (op)
            5'd25:   return z;
            5'd26:   return !z;
            5'd27:   return !z && (n == v);
            5'd28:   return n == v;
            5'd29:   return n != v;
            default: return z || (n != v);
        endcase
    endfunction

    task automatic step(input logic mr, input logic [31:0] iw, input logic [3:0] af,
                        input logic [16:0] exp, input logic [16:0] mask, input string tag);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.instr     = iw;
        bus.alu_flags = af;
        last_af       = af;
        #1;
        check(tag, 32'(observed() & mask), 32'(exp & mask));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_flags = 4'd0;
        m_trap  = 1'b0;
        #1;
        check("reset_async", 32'(observed()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", 32'(observed()), 32'd0);
    endtask

    task automatic run_instr(input logic [4:0] op, input logic imm_en, input int fw, input int mw,
                             input logic [3:0] sub_flags, input logic abort_in_mem);
        logic [31:0] iw;
        logic        alu, mem, jmp, sbi;
        iw        = $urandom;
        iw[31:27] = op;
        iw[14]    = imm_en;
        alu = op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12};
        mem = (op == 5'd17) || (op == 5'd19);
        jmp = (op >= 5'd25) && (op <= 5'd30);
        for (int w = 0; w < fw; w++)
            step(1'b0, $urandom, 4'($urandom), expv(5'd0, 0, 0, 0, 0, 0, 1, 0), FULL, "fetch_wait");
        step(1'b1, iw, 4'($urandom), expv(5'd0, 0, 1, 1, 0, 0, 1, 0), FULL, "fetch");
        step(1'($urandom), $urandom, 4'($urandom), expv(5'd0, 0, 0, 0, 0, 0, 0, 0), FULL, "decode");
        if (!alu && !mem && !jmp) begin
            m_trap = 1'b1;
            for (int t = 0; t < 5; t++)
                step(1'($urandom), $urandom, 4'($urandom), expv(5'd0, 0, 0, 0, 0, 0, 0, 0), FULL, "trap");
            return;
        end
        if (jmp) begin
            step(1'($urandom), $urandom, 4'($urandom),
                 expv(op, 0, 0, jump_taken(op, m_flags), 1, 0, 0, 0), FULL, "branch");
            return;
        end
        sbi = mem ? 1'b1 : imm_en;
        step(1'($urandom), $urandom, (op == 5'd2) ? sub_flags : 4'($urandom),
             expv(op, sbi, 0, 0, 0, 0, 0, 0), FULL, "exec");
        if (op == 5'd2) m_flags = last_af;
        if (mem) begin
            for (int w = 0; w < mw; w++)
                step(1'b0, $urandom, 4'($urandom), expv(op, 1, 0, 0, 0, 0, 1, op == 5'd19), NO_SBI, "mem_wait");
            if (abort_in_mem) return;
            step(1'b1, $urandom, 4'($urandom), expv(op, 1, 0, 0, 0, 0, 1, op == 5'd19), NO_SBI, "mem");
            if (op == 5'd19) return;
        end
        step(1'($urandom), $urandom, 4'($urandom), expv(5'd0, 0, 0, 0, 0, 1, 0, 0), FULL, "wb");
    endtask

    logic [4:0] legal_ops [16] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12,
                                   5'd17, 5'd19, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30};

    initial begin
        logic [4:0] op;
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.instr     = '0;
        bus.alu_flags = '0;
        do_reset();

        run_instr(5'd1,  1'b0, 0, 0, 4'd0, 1'b0);
        run_instr(5'd17, 1'b1, 0, 3, 4'd0, 1'b0);
        run_instr(5'd19, 1'b0, 1, 2, 4'd0, 1'b0);
        run_instr(5'd2,  1'b0, 0, 0, 4'b1000, 1'b0);
        run_instr(5'd25, 1'b0, 0, 0, 4'd0, 1'b0);
        run_instr(5'd26, 1'b0, 0, 0, 4'd0, 1'b0);
        run_instr(5'd2,  1'b1, 0, 0, 4'b0000, 1'b0);
        run_instr(5'd25, 1'b0, 0, 0, 4'd0, 1'b0);
        run_instr(5'd2,  1'b0, 0, 0, 4'b0100, 1'b0);
        for (int j = 27; j <= 30; j++)
            run_instr(5'(j), 1'b0, 0, 0, 4'd0, 1'b0);
        run_instr(5'd2,  1'b0, 0, 0, 4'b0101, 1'b0);
        run_instr(5'd27, 1'b0, 0, 0, 4'd0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            op = legal_ops[$urandom_range(0, 15)];
            run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                      4'($urandom), 1'b0);
        end

        run_instr(5'd17, 1'b0, 0, 2, 4'd0, 1'b1);
        do_reset();
        run_instr(5'd1, 1'b1, 0, 0, 4'd0, 1'b0);

        run_instr(5'd5, 1'b0, 0, 0, 4'd0, 1'b0);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            op = 5'($urandom);
            for (int t = 0; t < 64 && is_legal(op); t++) op = 5'($urandom);
            run_instr(op, 1'($urandom), $urandom_range(0, 1), 0, 4'd0, 1'b0);
            do_reset();
        end
        run_instr(5'd4, 1'b0, 0, 0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
